// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV32I-subset core: sequences fetch/decode/execute
// per instruction, drives datapath selects, memory handshake and retire accounting.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [2:0]       operation_control,
  output logic             illegal,
  output logic             retired,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [3:0] S_START    = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADR   = 4'd3;
  localparam logic [3:0] S_MEMREAD  = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_MEMWRITE = 4'd6;
  localparam logic [3:0] S_EXECUTER = 4'd7;
  localparam logic [3:0] S_EXECUTEI = 4'd8;
  localparam logic [3:0] S_ALUWB    = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_JAL      = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b110;

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;
  logic             w_alu_f3_ok;
  logic             w_retired;
  logic [2:0]       w_funct_op;

  assign w_alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_START:    w_next = S_FETCH;
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = (funct3 == 3'b010) ? S_MEMADR : S_TRAP;
          OP_RTYP:      w_next = w_alu_f3_ok ? S_EXECUTER : S_TRAP;
          OP_ITYP:      w_next = w_alu_f3_ok ? S_EXECUTEI : S_TRAP;
          OP_BR:        w_next = (funct3 == 3'b000) ? S_BEQ : S_TRAP;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_START;
    endcase
  end

  // funct7b5 only selects SUB for register-register ops; immediates always ADD.
  always_comb begin
    w_funct_op = ALU_ADD;
    case (funct3)
      3'b000:  w_funct_op = ((r_state == S_EXECUTER) && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  w_funct_op = ALU_AND;
      3'b110:  w_funct_op = ALU_OR;
      default: w_funct_op = ALU_ADD;
    endcase
  end

  assign w_retired = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BEQ) ||
                     ((r_state == S_MEMWRITE) && mem_ready);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_START;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
      if (w_retired) r_count <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    mem_req           = 1'b0;
    mem_write         = 1'b0;
    adr_src           = 1'b0;
    ir_write          = 1'b0;
    pc_write          = 1'b0;
    reg_write         = 1'b0;
    alu_src_a         = 2'b00;
    alu_src_b         = 2'b00;
    result_src        = 2'b00;
    operation_control = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a         = 2'b10;
        operation_control = w_funct_op;
      end
      S_EXECUTEI: begin
        alu_src_a         = 2'b10;
        alu_src_b         = 2'b01;
        operation_control = w_funct_op;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a         = 2'b10;
        operation_control = ALU_SUB;
        pc_write          = zero;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal      = r_illegal;
  assign retired      = w_retired;
  assign retire_count = r_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle traces built from the
// instruction-class rules, with random stalls, branch outcomes and don't-care inputs.
module tb_multicycle_control;
  localparam int unsigned CW = 4;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JL   = 7'b1101111;
  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] SUB  = 3'b001;
  localparam logic [2:0] ANDO = 3'b010;
  localparam logic [2:0] ORO  = 3'b110;

  logic clk = 1'b0;
  logic resetn, zero, mem_ready, funct7b5;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal, retired;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] operation_control;
  logic [CW-1:0] retire_count;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .operation_control(operation_control), .illegal(illegal), .retired(retired),
    .retire_count(retire_count)
  );

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] m_cnt;
  logic m_ill;
  logic [16:0] obs;

  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, operation_control, illegal, retired};

  function automatic logic [16:0] mk(input logic mreq, input logic mw, input logic adr,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] rs, input logic [2:0] op,
                                     input logic ret);
    return {mreq, mw, adr, irw, pcw, rw, a, b, rs, op, m_ill, ret};
  endfunction

  function automatic logic rb();
    return $urandom_range(0, 1) != 0;
  endfunction

  function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic b5);
    case (f3)
      3'b000:  return b5 ? SUB : ADD;
      3'b111:  return ANDO;
      3'b110:  return ORO;
      default: return ADD;
    endcase
  endfunction

  function automatic logic legal(input logic [6:0] opc, input logic [2:0] f3);
    if (opc == LW || opc == SW) return f3 == 3'b010;
    if (opc == RT || opc == IT) return f3 == 3'b000 || f3 == 3'b110 || f3 == 3'b111;
    if (opc == BR) return f3 == 3'b000;
    return opc == JL;
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One clock cycle: drive inputs, check outputs and count, then advance.
  task automatic cyc(input string tag, input logic mr, input logic z, input logic [16:0] e);
    mem_ready = mr;
    zero      = z;
    #1;
    check(tag, {15'd0, obs}, {15'd0, e});
    check({tag, "_cnt"}, {28'd0, retire_count}, {28'd0, m_cnt});
    if (e[0]) m_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 resetn = 1'b0;
    m_ill = 1'b0;
    #1;
    check("rst_outputs", {15'd0, obs}, 32'd0);
    check("rst_count", {28'd0, retire_count}, 32'd0);
    m_cnt = '0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    cyc("start", rb(), rb(), mk(0,0,0,0,0,0,2'd0,2'd0,2'd0,ADD,0));
  endtask

  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic b5,
                           input logic z, input int fstall, input int mstall);
    logic [16:0] aluwb;
    aluwb    = mk(0,0,0,0,0,1,2'd0,2'd0,2'd0,ADD,1);
    opcode   = opc;
    funct3   = f3;
    funct7b5 = b5;
    for (int i = 0; i < fstall; i++)
      cyc("fetch_wait", 1'b0, rb(), mk(1,0,0,0,0,0,2'd0,2'd2,2'd2,ADD,0));
    cyc("fetch", 1'b1, rb(), mk(1,0,0,1,1,0,2'd0,2'd2,2'd2,ADD,0));
    cyc("decode", rb(), rb(), mk(0,0,0,0,0,0,2'd1,2'd1,2'd0,ADD,0));
    if (!legal(opc, f3)) begin
      m_ill = 1'b1;
      return;
    end
    if (opc == LW || opc == SW) begin
      cyc("memadr", rb(), rb(), mk(0,0,0,0,0,0,2'd2,2'd1,2'd0,ADD,0));
      if (opc == LW) begin
        for (int i = 0; i < mstall; i++)
          cyc("memread_wait", 1'b0, rb(), mk(1,0,1,0,0,0,2'd0,2'd0,2'd0,ADD,0));
        cyc("memread", 1'b1, rb(), mk(1,0,1,0,0,0,2'd0,2'd0,2'd0,ADD,0));
        cyc("memwb", rb(), rb(), mk(0,0,0,0,0,1,2'd0,2'd0,2'd1,ADD,1));
      end else begin
        for (int i = 0; i < mstall; i++)
          cyc("memwrite_wait", 1'b0, rb(), mk(1,1,1,0,0,0,2'd0,2'd0,2'd0,ADD,0));
        cyc("memwrite", 1'b1, rb(), mk(1,1,1,0,0,0,2'd0,2'd0,2'd0,ADD,1));
      end
    end else if (opc == RT) begin
      cyc("execr", rb(), rb(), mk(0,0,0,0,0,0,2'd2,2'd0,2'd0,alu_op(f3, b5),0));
      cyc("aluwb", rb(), rb(), aluwb);
    end else if (opc == IT) begin
      cyc("execi", rb(), rb(), mk(0,0,0,0,0,0,2'd2,2'd1,2'd0,alu_op(f3, 1'b0),0));
      cyc("aluwb", rb(), rb(), aluwb);
    end else if (opc == BR) begin
      cyc("beq", rb(), z, mk(0,0,0,0,z,0,2'd2,2'd0,2'd0,SUB,1));
    end else begin
      cyc("jal", rb(), rb(), mk(0,0,0,0,1,0,2'd1,2'd2,2'd0,ADD,0));
      cyc("aluwb", rb(), rb(), aluwb);
    end
  endtask

  task automatic trap_cycles(input int n);
    for (int i = 0; i < n; i++)
      cyc("trap", rb(), rb(), mk(0,0,0,0,0,0,2'd0,2'd0,2'd0,ADD,0));
  endtask

  logic [2:0] f3s [3];
  logic [6:0] bad_opc;

  initial begin
    f3s       = '{3'b000, 3'b110, 3'b111};
    resetn    = 1'b0;
    mem_ready = 1'b0;
    zero      = 1'b0;
    opcode    = '0;
    funct3    = '0;
    funct7b5  = 1'b0;
    m_cnt     = '0;
    m_ill     = 1'b0;
    @(negedge clk);
    do_reset();

    run_instr(RT, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(RT, 3'b111, 1'b0, 1'b0, 0, 0);
    run_instr(RT, 3'b110, 1'b0, 1'b0, 0, 0);
    run_instr(IT, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 3);
    run_instr(BR, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr(BR, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(JL, 3'b101, 1'b1, 1'b0, 1, 0);
    run_instr(SW, 3'b010, 1'b0, 1'b0, 2, 2);

    // Random legal traffic; enough retirements to wrap the narrow counter twice.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: run_instr(RT, f3s[$urandom_range(0, 2)], rb(), 1'b0, $urandom_range(0, 2), 0);
        1: run_instr(IT, f3s[$urandom_range(0, 2)], rb(), 1'b0, $urandom_range(0, 2), 0);
        2: run_instr(LW, 3'b010, rb(), 1'b0, $urandom_range(0, 2), $urandom_range(0, 3));
        3: run_instr(SW, 3'b010, rb(), 1'b0, $urandom_range(0, 2), $urandom_range(0, 3));
        4: run_instr(BR, 3'b000, rb(), rb(), $urandom_range(0, 2), 0);
        default: run_instr(JL, 3'($urandom_range(0, 7)), rb(), 1'b0, $urandom_range(0, 2), 0);
      endcase
    end

    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
    trap_cycles(100);
    do_reset();

    run_instr(LW, 3'b000, 1'b0, 1'b0, 0, 0);
    trap_cycles(4);
    do_reset();
    run_instr(RT, 3'b001, 1'b0, 1'b0, 1, 0);
    trap_cycles(4);
    do_reset();
    run_instr(IT, 3'b100, 1'b1, 1'b0, 0, 0);
    trap_cycles(4);
    do_reset();
    run_instr(BR, 3'b001, 1'b0, 1'b1, 0, 0);
    trap_cycles(4);
    do_reset();
    bad_opc = 7'b0000000;
    run_instr(bad_opc, 3'b010, 1'b0, 1'b0, 0, 0);
    trap_cycles(4);
    do_reset();

    run_instr(RT, 3'b000, 1'b0, 1'b0, 0, 0);
    opcode   = SW;
    funct3   = 3'b010;
    funct7b5 = 1'b0;
    cyc("abort_fetch_wait", 1'b0, 1'b0, mk(1,0,0,0,0,0,2'd0,2'd2,2'd2,ADD,0));
    cyc("abort_fetch_wait", 1'b0, 1'b0, mk(1,0,0,0,0,0,2'd0,2'd2,2'd2,ADD,0));
    cyc("abort_fetch", 1'b1, 1'b0, mk(1,0,0,1,1,0,2'd0,2'd2,2'd2,ADD,0));
    cyc("abort_decode", 1'b0, 1'b0, mk(0,0,0,0,0,0,2'd1,2'd1,2'd0,ADD,0));
    cyc("abort_memadr", 1'b0, 1'b0, mk(0,0,0,0,0,0,2'd2,2'd1,2'd0,ADD,0));
    mem_ready = 1'b0;
    #1;
    check("abort_memwrite", {15'd0, obs}, {15'd0, mk(1,1,1,0,0,0,2'd0,2'd0,2'd0,ADD,0)});
    do_reset();
    run_instr(RT, 3'b111, 1'b0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the RV32I-subset processor.
- Decodes opcode/funct fields latched in the IR and sequences one instruction per 3–5 states.
- Drives the datapath muxes, memory request handshake, register-file write and the 3-bit ALU operation_control code consumed by the ALU.
- Also keeps a retired-instruction counter and a sticky illegal-instruction flag.

Parameters:
- CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  single system clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- opcode  in  7  instr[6:0] from IR.
- funct3  in  3  instr[14:12] from IR.
- funct7b5  in  1  instr[30] from IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes current request this cycle.
- mem_req  out  1  memory request valid.
- mem_write  out  1  request is a store (valid only with mem_req).
- adr_src  out  1  0 = PC, 1 = result bus.
- ir_write  out  1  load IR and old-PC register.
- pc_write  out  1  load PC from result bus.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  2  00 = PC, 01 = old PC, 10 = rs1 register.
- alu_src_b  out  2  00 = rs2 register, 01 = immediate, 10 = constant 4.
- result_src  out  2  00 = ALU-out register, 01 = memory-data register, 10 = ALU result direct.
- operation_control  out  3  000 ADD, 001 SUB, 010 AND, 110 OR.
- illegal  out  1  sticky, set on unsupported instruction.
- retired  out  1  one-cycle pulse per completed instruction.
- retire_count  out  CNT_W  number of completed instructions.

Behaviour:
- Reset (resetn = 0, async):
  - state = START; retire_count = 0; illegal = 0.
  - All strobes 0, all mux selects 0, operation_control = 000.
- Outputs are Moore-decoded from state; the only exceptions are the handshake-gated strobes and BEQ pc_write listed below.
- State actions and transitions:
  - START: all outputs 0 -> FETCH next cycle unconditionally.
  - FETCH: mem_req=1, adr_src=0, a=00, b=10, ADD, result_src=10.
    - ir_write = pc_write = mem_ready.
    - Stay while mem_ready=0; -> DECODE when mem_ready=1.
  - DECODE: a=01, b=01, ADD (branch/jump target into ALU-out). Dispatch on opcode:
    - 0000011 lw or 0100011 sw -> MEMADR.
    - 0110011 -> EXECUTER.
    - 0010011 -> EXECUTEI.
    - 1100011 -> BEQ.
    - 1101111 -> JAL.
    - Anything else -> TRAP.
  - Illegal in DECODE, also -> TRAP:
    - lw/sw with funct3 != 010.
    - R/I-type with funct3 not in {000, 110, 111}.
    - Branch with funct3 != 000.
  - MEMADR: a=10, b=01, ADD. -> MEMREAD if opcode = lw, else MEMWRITE.
  - MEMREAD: mem_req=1, adr_src=1, result_src=00. Stay until mem_ready -> MEMWB.
  - MEMWB: result_src=01, reg_write=1 -> FETCH.
  - MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00. Stay until mem_ready -> FETCH.
  - EXECUTER: a=10, b=00, op from funct -> ALUWB.
    - funct3 000: SUB if funct7b5, else ADD.
    - funct3 111: AND.
    - funct3 110: OR.
  - EXECUTEI: a=10, b=01, same funct3 mapping as EXECUTER but funct7b5 ignored (000 always ADD) -> ALUWB.
  - ALUWB: result_src=00, reg_write=1 -> FETCH.
  - BEQ: a=10, b=00, SUB, result_src=00, pc_write = zero (combinational) -> FETCH.
  - JAL: a=01, b=10, ADD, result_src=00, pc_write=1 -> ALUWB (writes PC+4 to rd).
  - TRAP: all strobes 0, illegal=1. Stays in TRAP until reset; no memory requests issued.
- Retire: retired=1 on the cycle of the final state of an instruction:
  - MEMWB, ALUWB, BEQ.
  - MEMWRITE when mem_ready=1.
  - retire_count increments on that same edge; wraps to 0 at 2^CNT_W-1.
  - JAL retires in its ALUWB, counted once.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Inputs opcode/funct3/funct7b5 are only sampled from DECODE onward (IR stable).
- Reset asserted mid-instruction aborts immediately to START. No partial writes are required to complete; an outstanding mem_req drops asynchronously.

Test Plan:
- Release reset, mem_ready=1, IR add (0110011/000/b5=0) -> states START, FETCH, DECODE, EXECUTER (operation_control 000, a=10, b=00), ALUWB (reg_write=1, retired=1); retire_count=1 after 5 cycles.
- IR sub (b5=1), then and (111), then or (110) -> EXECUTER operation_control 001, 010, 110 respectively; addi with b5=1 -> 000.
- lw with mem_ready low for 3 cycles in MEMREAD -> mem_req=1, adr_src=1 held 4 cycles; then MEMWB with result_src=01, reg_write=1; no ir_write/pc_write outside FETCH.
- beq with zero=1 -> pc_write=1 in BEQ and operation_control=001; zero=0 -> pc_write=0; both retire.
- opcode 1111111 -> TRAP, illegal=1 stays set 100 cycles, mem_req=0; retire_count unchanged; resetn pulse -> illegal=0, state START.
- Stall FETCH with mem_ready=0 for 2 cycles, then assert resetn=0 mid-MEMWRITE -> all outputs 0 asynchronously; retire_count=0.
